// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizing constants and FSM state type for the CNN 1D stream feeder.
package cnn_pkg;

    localparam int unsigned IMG_LEN   = 7;
    localparam int unsigned K         = 3;
    localparam int unsigned DW        = 4;
    localparam int unsigned RW        = 10;
    localparam int unsigned RD_LAT    = 1;

    localparam int unsigned NUM_WIN   = IMG_LEN - K + 1;
    localparam int unsigned NUM_PAIRS = NUM_WIN * K;
    localparam int unsigned RD_CYC    = RD_LAT + NUM_WIN;

    localparam int unsigned IW  = $clog2(IMG_LEN);
    localparam int unsigned FW  = $clog2(K);
    localparam int unsigned WW  = $clog2(NUM_WIN);
    localparam int unsigned RCW = $clog2(RD_CYC);
    localparam int unsigned AW  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        GAP    = 3'd2,
        READ   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cnn_window_addr_gen.sv
// cnn_window_addr_gen: window/tap counters for the pair stream, window-major, tap-minor.
// The counters point at the next pair to be issued; o_last_pair flags that this pair is the final one.
module cnn_window_addr_gen
    import cnn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_step,
    output logic [IW-1:0] o_img_idx,
    output logic [FW-1:0] o_flt_idx,
    output logic          o_last_pair
);

    logic [WW-1:0] r_win;
    logic [FW-1:0] r_tap;
    logic          w_tap_last;
    logic          w_win_last;

    assign w_tap_last  = (r_tap == FW'(K - 1));
    assign w_win_last  = (r_win == WW'(NUM_WIN - 1));
    assign o_last_pair = w_tap_last && w_win_last;
    assign o_img_idx   = IW'(r_win) + IW'(r_tap);
    assign o_flt_idx   = r_tap;

    // Advance tap, then window; hold on the last pair so indices never pass IMG_LEN-1.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_win <= '0;
            r_tap <= '0;
        end else if (i_step && !o_last_pair) begin
            if (w_tap_last) begin
                r_tap <= '0;
                r_win <= r_win + 1'b1;
            end else begin
                r_tap <= r_tap + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_stream_feeder.sv
// cnn_stream_feeder: holds image/filter buffers, streams Image/Filter pairs with Start to the
// CNN layer, then drives ReadEn and captures ConvResult per window.
// Optional macro CNN_FEEDER_SELFCHECK_EN adds a golden MAC that flags mismatching results on chk_err.
module cnn_stream_feeder
    import cnn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Image,
    output logic [DW-1:0] Filter,
    output logic          Start,
    output logic          ReadEn,
    input  logic [RW-1:0] ConvResult,
    output logic          res_valid,
    output logic [AW-1:0] res_idx,
    output logic [RW-1:0] res_data,
    output logic          chk_err
);

    logic [DW-1:0]  r_img [IMG_LEN];
    logic [DW-1:0]  r_flt [K];

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic [DW-1:0]  r_image;
    logic [DW-1:0]  r_filter;
    logic           r_start;
    logic           r_readen;
    logic           r_res_valid;
    logic [AW-1:0]  r_res_idx;
    logic [RW-1:0]  r_res_data;
    logic           r_last_issued;
    logic [RCW-1:0] r_rd_cnt;

    logic [IW-1:0]  w_img_idx;
    logic [FW-1:0]  w_flt_idx;
    logic           w_last_pair;
    logic           w_accept;
    logic           w_step;
    logic           w_clear;
    logic           w_capture;

    assign w_accept  = (r_state == IDLE) && go;
    assign w_step    = w_accept || ((r_state == STREAM) && !r_last_issued);
    assign w_clear   = (r_state == GAP);
    assign w_capture = (r_state == READ) && (r_rd_cnt >= RCW'(RD_LAT));

    cnn_window_addr_gen u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_step      (w_step),
        .o_img_idx   (w_img_idx),
        .o_flt_idx   (w_flt_idx),
        .o_last_pair (w_last_pair)
    );

    // Host configuration writes; dropped while a run is in progress or when out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < IMG_LEN; i++) r_img[i] <= '0;
            for (int unsigned i = 0; i < K; i++)       r_flt[i] <= '0;
        end else if (cfg_we && !r_busy) begin
            if (!cfg_sel) begin
                if (32'(cfg_addr) < IMG_LEN) r_img[cfg_addr[IW-1:0]] <= cfg_data;
            end else begin
                if (32'(cfg_addr) < K) r_flt[cfg_addr[FW-1:0]] <= cfg_data;
            end
        end
    end

    // Run sequencer: pair stream, one-cycle gap, readout with capture, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_image       <= '0;
            r_filter      <= '0;
            r_start       <= 1'b0;
            r_readen      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_idx     <= '0;
            r_res_data    <= '0;
            r_last_issued <= 1'b0;
            r_rd_cnt      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_data  <= ConvResult;
                r_res_idx   <= AW'(r_rd_cnt - RCW'(RD_LAT));
            end
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_state       <= STREAM;
                        r_busy        <= 1'b1;
                        r_start       <= 1'b1;
                        r_image       <= r_img[w_img_idx];
                        r_filter      <= r_flt[w_flt_idx];
                        r_last_issued <= w_last_pair;
                    end
                end
                STREAM: begin
                    if (r_last_issued) begin
                        r_state  <= GAP;
                        r_start  <= 1'b0;
                        r_image  <= '0;
                        r_filter <= '0;
                    end else begin
                        r_image       <= r_img[w_img_idx];
                        r_filter      <= r_flt[w_flt_idx];
                        r_last_issued <= w_last_pair;
                    end
                end
                GAP: begin
                    r_state  <= READ;
                    r_readen <= 1'b1;
                    r_rd_cnt <= '0;
                end
                READ: begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (r_rd_cnt == RCW'(RD_CYC - 1)) begin
                        r_state  <= DONE;
                        r_readen <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CNN_FEEDER_SELFCHECK_EN
    logic [RCW-1:0] w_chk_win;
    logic [RW-1:0]  w_golden;
    logic           r_chk_err;

    // Golden MAC for the window being captured this cycle.
    always_comb begin
        w_chk_win = w_capture ? (r_rd_cnt - RCW'(RD_LAT)) : '0;
        w_golden  = '0;
        for (int unsigned t = 0; t < K; t++) begin
            w_golden = w_golden
                     + RW'(r_img[IW'(w_chk_win) + IW'(t)]) * RW'(r_flt[FW'(t)]);
        end
    end

    // Sticky mismatch flag, cleared by reset or an accepted go.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_chk_err <= 1'b0;
        end else if (w_capture && (ConvResult != w_golden)) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign Image     = r_image;
    assign Filter    = r_filter;
    assign Start     = r_start;
    assign ReadEn    = r_readen;
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_data  = r_res_data;

endmodule
